// File: rtl/snooper_pkg.sv
// snooper_pkg
//   Shared definitions for the AXI-Stream packet snooper:
//   - state_e        : capture FSM states
//   - byte_len_width : width of the reported byte length for a given
//                      buffer address width and bytes-per-flit
//   - sat_inc        : saturating increment, used for the drop counter
package snooper_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    OVERFLOW = 2'd2,
    DROP     = 2'd3
  } state_e;

  // Wide enough for MAX_FLITS*BYTES, where MAX_FLITS <= 2**addr_w.
  function automatic int byte_len_width(input int addr_w, input int bytes);
    return addr_w + $clog2(bytes) + 1;
  endfunction

  // Increment that sticks at max. Callers zero-extend narrower counters
  // (up to 32 bits) into this function and truncate the result back.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max);
    return (val >= max) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/keep_popcount.sv
// keep_popcount
//   Combinational count of set bits in an AXI-Stream tkeep vector.
//   Ports:
//     keep  in  BYTES            byte enables
//     count out $clog2(BYTES)+1  number of set bits
module keep_popcount #(
  parameter int BYTES = 4,
  localparam int CNT_W = $clog2(BYTES) + 1
) (
  input  logic [BYTES-1:0] keep,
  output logic [CNT_W-1:0] count
);

  // Sum of the individual keep bits.
  always_comb begin
    count = {CNT_W{1'b0}};
    for (int i = 0; i < BYTES; i++) begin
      count = count + CNT_W'(keep[i]);
    end
  end

endmodule

// File: rtl/axis_packet_snooper.sv
// axis_packet_snooper
//   Passive AXI-Stream tap that copies each observed packet into a
//   single-packet buffer, reports its byte length and truncation on a
//   one-cycle done pulse, and counts packets dropped because no buffer
//   was free at the first beat.
//   Ports:
//     clk, rst_n                        clock, async active-low reset
//     snoop_tdata/tkeep/tvalid/tready/tlast  observed stream (input only)
//     mem_ready                         a free packet buffer exists
//     wr_addr, wr_data, wr_en           packet-memory write port
//     done, byte_len, truncated         packet completion report
//     drop_count                        saturating dropped-packet count
module axis_packet_snooper
  import snooper_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int MAX_FLITS      = 1024,
  parameter int DROP_CNT_WIDTH = 16,
  localparam int BYTES = DATA_WIDTH / 8,
  localparam int LEN_W = byte_len_width(ADDR_WIDTH, BYTES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     snoop_tdata,
  input  logic [BYTES-1:0]          snoop_tkeep,
  input  logic                      snoop_tvalid,
  input  logic                      snoop_tready,
  input  logic                      snoop_tlast,
  input  logic                      mem_ready,
  output logic [ADDR_WIDTH-1:0]     wr_addr,
  output logic [DATA_WIDTH-1:0]     wr_data,
  output logic                      wr_en,
  output logic                      done,
  output logic [LEN_W-1:0]          byte_len,
  output logic                      truncated,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int POP_W = $clog2(BYTES) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(MAX_FLITS - 1);
  localparam logic [LEN_W-1:0] TRUNC_LEN = LEN_W'(MAX_FLITS * BYTES);
  localparam logic [31:0]      DROP_MAX  = 32'((64'd1 << DROP_CNT_WIDTH) - 64'd1);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]     wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
  logic                      wr_en_q, wr_en_d;
  logic                      done_q, done_d;
  logic [LEN_W-1:0]          byte_len_q, byte_len_d;
  logic                      truncated_q, truncated_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;

  logic [POP_W-1:0] pop_s;
  logic             beat_s;
  logic             capture_beat_s;
  logic [CNT_W-1:0] cur_idx_s;

  keep_popcount #(.BYTES(BYTES)) u_keep_popcount (
    .keep  (snoop_tkeep),
    .count (pop_s)
  );

  // Next-state, address counter and output-register values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    done_d      = 1'b0;
    byte_len_d  = byte_len_q;
    truncated_d = 1'b0;
    drop_d      = drop_q;

    beat_s = snoop_tvalid && snoop_tready;
    // mem_ready only matters on the first beat; once in CAPTURE the
    // packet is committed and written in full.
    capture_beat_s = beat_s &&
                     (((state_q == IDLE) && mem_ready) || (state_q == CAPTURE));
    // A first beat always lands at word 0.
    cur_idx_s = (state_q == IDLE) ? {CNT_W{1'b0}} : cnt_q;

    if (capture_beat_s) begin
      wr_en_d   = 1'b1;
      wr_addr_d = cur_idx_s[ADDR_WIDTH-1:0];
      wr_data_d = snoop_tdata;
      if (snoop_tlast) begin
        done_d     = 1'b1;
        byte_len_d = LEN_W'(cur_idx_s) * LEN_W'(BYTES) + LEN_W'(pop_s);
        state_d    = IDLE;
        cnt_d      = {CNT_W{1'b0}};
      end else if (cur_idx_s == LAST_IDX) begin
        // Buffer full and more flits to come.
        state_d = OVERFLOW;
        cnt_d   = {CNT_W{1'b0}};
      end else begin
        state_d = CAPTURE;
        cnt_d   = cur_idx_s + CNT_W'(1);
      end
    end else if (beat_s) begin
      case (state_q)
        IDLE: begin
          // First beat with no free buffer.
          if (snoop_tlast) begin
            drop_d = DROP_CNT_WIDTH'(sat_inc(32'(drop_q), DROP_MAX));
          end else begin
            state_d = DROP;
          end
        end
        OVERFLOW: begin
          if (snoop_tlast) begin
            done_d      = 1'b1;
            truncated_d = 1'b1;
            byte_len_d  = TRUNC_LEN;
            state_d     = IDLE;
          end else begin
            state_d = OVERFLOW;
          end
        end
        DROP: begin
          if (snoop_tlast) begin
            drop_d  = DROP_CNT_WIDTH'(sat_inc(32'(drop_q), DROP_MAX));
            state_d = IDLE;
          end else begin
            state_d = DROP;
          end
        end
        CAPTURE: begin
          state_d = CAPTURE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      wr_addr_q   <= {ADDR_WIDTH{1'b0}};
      wr_data_q   <= {DATA_WIDTH{1'b0}};
      wr_en_q     <= 1'b0;
      done_q      <= 1'b0;
      byte_len_q  <= {LEN_W{1'b0}};
      truncated_q <= 1'b0;
      drop_q      <= {DROP_CNT_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      done_q      <= done_d;
      byte_len_q  <= byte_len_d;
      truncated_q <= truncated_d;
      drop_q      <= drop_d;
    end
  end

  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_en      = wr_en_q;
  assign done       = done_q;
  assign byte_len   = byte_len_q;
  assign truncated  = truncated_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_axis_packet_snooper.sv
// tb_axis_packet_snooper
//   Directed bench for axis_packet_snooper with MAX_FLITS=4 and a 2-bit
//   drop counter so overflow and saturation are reachable quickly.
//   Inputs change 1 time unit after a rising edge; outputs are sampled at
//   the same point, i.e. they reflect the beat presented one cycle earlier.
module tb_axis_packet_snooper;

  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int MF  = 4;
  localparam int DCW = 2;
  localparam int LW  = 13;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [DW-1:0]  snoop_tdata;
  logic [3:0]     snoop_tkeep;
  logic           snoop_tvalid;
  logic           snoop_tready;
  logic           snoop_tlast;
  logic           mem_ready;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic           wr_en;
  logic           done;
  logic [LW-1:0]  byte_len;
  logic           truncated;
  logic [DCW-1:0] drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  axis_packet_snooper #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .MAX_FLITS      (MF),
    .DROP_CNT_WIDTH (DCW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .snoop_tdata  (snoop_tdata),
    .snoop_tkeep  (snoop_tkeep),
    .snoop_tvalid (snoop_tvalid),
    .snoop_tready (snoop_tready),
    .snoop_tlast  (snoop_tlast),
    .mem_ready    (mem_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .done         (done),
    .byte_len     (byte_len),
    .truncated    (truncated),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the given inputs; returns 1 unit after the edge.
  task automatic cyc(input logic v, input logic r, input logic l,
                     input logic [3:0] k, input logic [31:0] d,
                     input logic mr);
    snoop_tvalid = v;
    snoop_tready = r;
    snoop_tlast  = l;
    snoop_tkeep  = k;
    snoop_tdata  = d;
    mem_ready    = mr;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic l, input logic [3:0] k,
                      input logic [31:0] d, input logic mr);
    cyc(1'b1, 1'b1, l, k, d, mr);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
  endtask

  // Address/data are only meaningful on writes, length/truncation on done.
  task automatic expect_out(input string tag, input logic en,
                            input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic dn, input logic [LW-1:0] bl,
                            input logic tr);
    check_val({tag, ".wr_en"}, 64'(wr_en), 64'(en));
    if (en) begin
      check_val({tag, ".wr_addr"}, 64'(wr_addr), 64'(a));
      check_val({tag, ".wr_data"}, 64'(wr_data), 64'(d));
    end
    check_val({tag, ".done"}, 64'(done), 64'(dn));
    if (dn) begin
      check_val({tag, ".byte_len"}, 64'(byte_len), 64'(bl));
      check_val({tag, ".truncated"}, 64'(truncated), 64'(tr));
    end
  endtask

  task automatic expect_zero(input string tag);
    check_val({tag, ".wr_en"},      64'(wr_en),      64'd0);
    check_val({tag, ".wr_addr"},    64'(wr_addr),    64'd0);
    check_val({tag, ".wr_data"},    64'(wr_data),    64'd0);
    check_val({tag, ".done"},       64'(done),       64'd0);
    check_val({tag, ".byte_len"},   64'(byte_len),   64'd0);
    check_val({tag, ".truncated"},  64'(truncated),  64'd0);
    check_val({tag, ".drop_count"}, 64'(drop_count), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    snoop_tvalid = 1'b0; snoop_tready = 1'b0; snoop_tlast = 1'b0;
    snoop_tkeep = 4'h0; snoop_tdata = 32'h0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_zero("reset");
    rst_n = 1'b1;
    idle();

    // 3-beat packet, last keep 0011 -> 2*4+2 = 10 bytes
    beat(1'b0, 4'hF, 32'hA000_0000, 1'b1); expect_out("fix.b1", 1'b1, 10'd0, 32'hA000_0000, 1'b0, 13'd0, 1'b0);
    beat(1'b0, 4'hF, 32'hA000_0001, 1'b1); expect_out("fix.b2", 1'b1, 10'd1, 32'hA000_0001, 1'b0, 13'd0, 1'b0);
    beat(1'b1, 4'h3, 32'hA000_0002, 1'b1); expect_out("fix.b3", 1'b1, 10'd2, 32'hA000_0002, 1'b1, 13'd10, 1'b0);
    idle(); expect_out("fix.idle", 1'b0, 10'd0, 32'h0, 1'b0, 13'd0, 1'b0);

    // single beat then a 2-beat packet with no gap
    beat(1'b1, 4'hF, 32'hB000_0000, 1'b1); expect_out("b2b.single", 1'b1, 10'd0, 32'hB000_0000, 1'b1, 13'd4, 1'b0);
    beat(1'b0, 4'hF, 32'hB100_0000, 1'b1); expect_out("b2b.p2b1", 1'b1, 10'd0, 32'hB100_0000, 1'b0, 13'd0, 1'b0);
    beat(1'b1, 4'h1, 32'hB100_0001, 1'b1); expect_out("b2b.p2b2", 1'b1, 10'd1, 32'hB100_0001, 1'b1, 13'd5, 1'b0);

    // 6-beat packet into a 4-flit buffer
    for (int i = 0; i < 4; i++) begin
      beat(1'b0, 4'hF, 32'hC000_0000 + 32'(i), 1'b1);
      expect_out("ovf.wr", 1'b1, 10'(i), 32'hC000_0000 + 32'(i), 1'b0, 13'd0, 1'b0);
    end
    beat(1'b0, 4'hF, 32'hC000_0004, 1'b1); expect_out("ovf.b5", 1'b0, 10'd0, 32'h0, 1'b0, 13'd0, 1'b0);
    beat(1'b1, 4'h1, 32'hC000_0005, 1'b1); expect_out("ovf.b6", 1'b0, 10'd0, 32'h0, 1'b1, 13'd16, 1'b1);
    idle(); expect_out("ovf.idle", 1'b0, 10'd0, 32'h0, 1'b0, 13'd0, 1'b0);

    // exactly MAX_FLITS beats, last keep 0111 -> 3*4+3 = 15, not truncated
    for (int i = 0; i < 3; i++) begin
      beat(1'b0, 4'hF, 32'hD000_0000 + 32'(i), 1'b1);
      expect_out("exact.wr", 1'b1, 10'(i), 32'hD000_0000 + 32'(i), 1'b0, 13'd0, 1'b0);
    end
    beat(1'b1, 4'h7, 32'hD000_0003, 1'b1); expect_out("exact.last", 1'b1, 10'd3, 32'hD000_0003, 1'b1, 13'd15, 1'b0);

    // drop: mem_ready low on first beat only
    check_val("drop.before", 64'(drop_count), 64'd0);
    beat(1'b0, 4'hF, 32'hE000_0000, 1'b0); expect_out("drop.b1", 1'b0, 10'd0, 32'h0, 1'b0, 13'd0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      beat(1'b0, 4'hF, 32'hE000_0000 + 32'(i), 1'b1);
      expect_out("drop.mid", 1'b0, 10'd0, 32'h0, 1'b0, 13'd0, 1'b0);
    end
    check_val("drop.pending", 64'(drop_count), 64'd0);
    beat(1'b1, 4'hF, 32'hE000_0004, 1'b1); expect_out("drop.last", 1'b0, 10'd0, 32'h0, 1'b0, 13'd0, 1'b0);
    check_val("drop.after", 64'(drop_count), 64'd1);
    beat(1'b0, 4'hF, 32'hE100_0000, 1'b1); expect_out("drop.next1", 1'b1, 10'd0, 32'hE100_0000, 1'b0, 13'd0, 1'b0);
    beat(1'b1, 4'hF, 32'hE100_0001, 1'b1); expect_out("drop.next2", 1'b1, 10'd1, 32'hE100_0001, 1'b1, 13'd8, 1'b0);
    check_val("drop.hold", 64'(drop_count), 64'd1);
    // three more single-beat drops saturate the 2-bit counter at 3
    beat(1'b1, 4'hF, 32'hE200_0000, 1'b0); check_val("drop.cnt2", 64'(drop_count), 64'd2);
    beat(1'b1, 4'hF, 32'hE200_0001, 1'b0); check_val("drop.cnt3", 64'(drop_count), 64'd3);
    beat(1'b1, 4'hF, 32'hE200_0002, 1'b0); check_val("drop.sat", 64'(drop_count), 64'd3);
    expect_out("drop.sat.out", 1'b0, 10'd0, 32'h0, 1'b0, 13'd0, 1'b0);

    // stalls: tready low and tvalid low cycles between beats
    beat(1'b0, 4'hF, 32'hF000_0000, 1'b1); expect_out("stall.b1", 1'b1, 10'd0, 32'hF000_0000, 1'b0, 13'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 4'h1, 32'hDEAD_BEEF, 1'b1); expect_out("stall.nordy", 1'b0, 10'd0, 32'h0, 1'b0, 13'd0, 1'b0);
    beat(1'b0, 4'hF, 32'hF000_0001, 1'b1); expect_out("stall.b2", 1'b1, 10'd1, 32'hF000_0001, 1'b0, 13'd0, 1'b0);
    idle(); expect_out("stall.novld", 1'b0, 10'd0, 32'h0, 1'b0, 13'd0, 1'b0);
    beat(1'b1, 4'hF, 32'hF000_0002, 1'b1); expect_out("stall.b3", 1'b1, 10'd2, 32'hF000_0002, 1'b1, 13'd12, 1'b0);

    // mem_ready falls after the first beat: packet still written in full
    beat(1'b0, 4'hF, 32'h1000_0000, 1'b1); expect_out("commit.b1", 1'b1, 10'd0, 32'h1000_0000, 1'b0, 13'd0, 1'b0);
    beat(1'b0, 4'hF, 32'h1000_0001, 1'b0); expect_out("commit.b2", 1'b1, 10'd1, 32'h1000_0001, 1'b0, 13'd0, 1'b0);
    beat(1'b1, 4'h3, 32'h1000_0002, 1'b0); expect_out("commit.b3", 1'b1, 10'd2, 32'h1000_0002, 1'b1, 13'd10, 1'b0);

    // reset after 2 of 4 beats
    beat(1'b0, 4'hF, 32'h2000_0000, 1'b1); expect_out("rst.b1", 1'b1, 10'd0, 32'h2000_0000, 1'b0, 13'd0, 1'b0);
    beat(1'b0, 4'hF, 32'h2000_0001, 1'b1); expect_out("rst.b2", 1'b1, 10'd1, 32'h2000_0001, 1'b0, 13'd0, 1'b0);
    rst_n = 1'b0;
    snoop_tvalid = 1'b0;
    #1;
    expect_zero("rst.async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    beat(1'b0, 4'hF, 32'h2000_0002, 1'b1); expect_out("rst.b3", 1'b1, 10'd0, 32'h2000_0002, 1'b0, 13'd0, 1'b0);
    beat(1'b1, 4'h3, 32'h2000_0003, 1'b1); expect_out("rst.b4", 1'b1, 10'd1, 32'h2000_0003, 1'b1, 13'd6, 1'b0);
    idle(); expect_out("end.idle", 1'b0, 10'd0, 32'h0, 1'b0, 13'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_packet_snooper.md
# axis_packet_snooper

Passive, parametrised packet snooper for AXI-Stream links: copies each observed packet, flit by flit, into a single-packet buffer in packet memory. It supports variable-length packets delimited by `tlast`, a byte-accurate length from `tkeep`, and truncation at a configurable maximum. Packets that arrive while memory is not ready are dropped whole and counted. It sits between a tapped AXI-Stream bus and the packet-memory write port, and supersedes the fixed-length data+valid snooper.

## Interface
- `DATA_WIDTH`, 32: flit width in bits; multiple of 8. `BYTES = DATA_WIDTH/8`.
- `ADDR_WIDTH`, 10: packet-memory word-address width.
- `MAX_FLITS`, 1024: flits stored per packet; must be ≤ 2^ADDR_WIDTH.
- `DROP_CNT_WIDTH`, 16: width of the drop counter.
- `clk` in 1: sole clock. One clock; reset is asynchronous and active-low.
- `rst_n` in 1: asynchronous, active-low reset.
- `snoop_tdata` in DATA_WIDTH: observed data.
- `snoop_tkeep` in BYTES: observed byte enables; contiguous and low-aligned.
- `snoop_tvalid`, `snoop_tready`, `snoop_tlast` in 1 each: observed handshake. A beat is `tvalid && tready`.
- `mem_ready` in 1: a free packet buffer is available.
- `wr_addr` out ADDR_WIDTH: word address within the buffer.
- `wr_data` out DATA_WIDTH: flit to write.
- `wr_en` out 1: write strobe.
- `done` out 1: one-cycle pulse when a captured packet is complete.
- `byte_len` out ADDR_WIDTH+$clog2(BYTES)+1: byte length of the stored packet; valid while `done`=1.
- `truncated` out 1: the packet exceeded MAX_FLITS; valid while `done`=1.
- `drop_count` out DROP_CNT_WIDTH: saturating count of dropped packets.

## Operation
- FSM states: IDLE, CAPTURE, OVERFLOW, DROP.
- **IDLE**, beat arrives:
  - `mem_ready`=1: write the flit at address 0. Go to CAPTURE, or if `tlast`=1, finish immediately (`done`).
  - `mem_ready`=0: no write. Go to DROP, or if `tlast`=1, increment `drop_count` and stay in IDLE.
- **Commit rule:** `mem_ready` is sampled only on the first beat. Once a packet is accepted it is committed and written in full, regardless of later `mem_ready` values.
- **CAPTURE**, each beat: write at `addr`, then `addr`+1.
  - If `tlast`: `done`, return to IDLE, `addr`←0.
  - If this beat was flit number MAX_FLITS and not `tlast`: go to OVERFLOW.
- **OVERFLOW:** beats are not written.
  - On `tlast`: `done` with `truncated`=1 and `wr_en`=0; return to IDLE.
- **DROP:** beats are ignored.
  - On `tlast`: increment `drop_count` (saturating at all-ones); return to IDLE.
- **Length:**
  - Normal packet: `byte_len` = (flits−1)·BYTES + popcount(`tkeep` of the last beat).
  - Truncated packet: `byte_len` = MAX_FLITS·BYTES.
  - A packet of exactly MAX_FLITS flits is not truncated.
- **Data path:** `wr_data` is the registered `snoop_tdata`; `tkeep` is not applied to the data.

## Timing
- All outputs are registered.
  - `wr_en`, `wr_addr` and `wr_data` appear exactly 1 cycle after the beat.
  - `done`, `byte_len` and `truncated` are asserted in the same cycle as the final `wr_en`, or 1 cycle after the `tlast` beat when in OVERFLOW.
- Back-to-back packets: a beat in the cycle immediately after a `tlast` beat is treated as a new first beat. No gap cycles are needed.
- Beats with gaps (tvalid=0 or tready=0) cause no action; state is held.
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `done`=0, `byte_len`=0, `truncated`=0, `drop_count`=0, state IDLE.
- Reset mid-packet:
  - Any partial capture is abandoned with no `done`.
  - The first beat after reset release is treated as a packet start, even if upstream is mid-packet.

## Structure
- Shared package `snooper_pkg`:
  - State enum (IDLE, CAPTURE, OVERFLOW, DROP).
  - Function for the `byte_len` width.
  - Saturating-increment helper.
- One sub-module, `keep_popcount`:
  - Parametrised on BYTES.
  - Combinational count of set bits in `tkeep`, output width $clog2(BYTES)+1.
- Top level contains the FSM, the address counter and the output registers.

## Test plan
- **Fixed-length packet:** DATA_WIDTH=32, a 3-beat packet with last `tkeep`=4'b0011 and `mem_ready`=1.
  - Expect writes at addresses 0,1,2 on cycles t+1..t+3.
  - Expect `done` on the address-2 write with `byte_len`=10 and `truncated`=0.
- **Single-beat and back-to-back:** a 1-beat packet with `tkeep`=4'b1111, immediately followed by a 2-beat packet.
  - Expect `done` with `byte_len`=4.
  - Then writes to addresses 0,1 and `done` with `byte_len`=5 (last `tkeep`=4'b0001).
- **Overflow:** MAX_FLITS=4, a 6-beat packet.
  - Expect writes to addresses 0..3 only.
  - Expect `done` 1 cycle after beat 6 with `wr_en`=0, `truncated`=1, `byte_len`=16.
  - A packet of exactly 4 beats gives `truncated`=0.
- **Drop:** `mem_ready`=0 on the first beat and 1 afterwards, with a 5-beat packet.
  - Expect no writes and no `done`; `drop_count` 0→1 after `tlast`.
  - The next packet is captured normally.
  - With DROP_CNT_WIDTH=2, four drops leave `drop_count`=3.
- **Stalls and commit:**
  - Beats gapped with `tready`=0: expect addresses to stay contiguous.
  - `mem_ready` falling mid-packet: expect all flits still written.
- **Reset mid-packet:** assert `rst_n`=0 after 2 of 4 beats.
  - Expect all outputs 0 immediately.
  - After release, the next beat writes at address 0.
